// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared constants, atan table, gain term list and FSM states
//            for the cordic_multi engine.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam logic MODE_VECT = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

    // atan(2^-i) / pi scaled to 2^31; consumers keep the top WIDTH bits
    localparam logic [31:0] c_ATAN_TABLE [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // K ~= 0.6072529 as 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-15 - 2^-16
    // (K has settled to this value for any iteration count of ten or more)
    localparam int         c_K_TERMS            = 7;
    localparam int         c_K_SHIFT [c_K_TERMS] = '{1, 3, 6, 9, 13, 15, 16};
    localparam logic [6:0] c_K_SUB              = 7'b1111100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_COMP = 3'd3,
        S_OUT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan_rom
// Purpose  : Combinational micro-rotation angle lookup, atan(2^-i) as a
//            WIDTH-bit binary angle.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [4:0]              i_idx,
    output logic signed [WIDTH-1:0] o_atan
);

    assign o_atan = WIDTH'(c_ATAN_TABLE[i_idx] >> (32 - WIDTH));

endmodule
`default_nettype wire

// File: rtl/cordic_multi.sv
`default_nettype none
// ============================================================================
// Module   : cordic_multi
// Purpose  : Iterative four-quadrant CORDIC, vectoring (atan2/magnitude) and
//            rotation modes. Define CORDIC_GAIN_COMP_EN for true-scale x/y.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_multi
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int ITERATIONS = 12,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    crd_start,
    input  logic                    crd_mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    crd_busy,
    output logic                    crd_done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    localparam int c_IW = WIDTH + 2 * GUARD;

    localparam logic [4:0]              c_LAST = 5'(ITERATIONS - 1);
    localparam logic signed [WIDTH-1:0] c_PI   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_QTR  = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_NQTR = {2'b11, {(WIDTH-2){1'b0}}};
    localparam logic signed [c_IW:0]    c_HALF = (c_IW+1)'(1) << (GUARD - 1);
    localparam logic signed [c_IW:0]    c_MAX  = {{(2*GUARD+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_IW:0]    c_MIN  = {{(2*GUARD+2){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t c_AFTER_ITER = S_COMP;
`else
    localparam state_t c_AFTER_ITER = S_OUT;
`endif

    state_t                  r_state;
    logic                    r_mode;
    logic                    r_zero;
    logic [4:0]              r_i;
    logic signed [c_IW-1:0]  r_x;
    logic signed [c_IW-1:0]  r_y;
    logic signed [WIDTH-1:0] r_z;

    logic signed [c_IW-1:0]  w_xs;
    logic signed [c_IW-1:0]  w_ys;
    logic signed [WIDTH-1:0] w_atan;
    logic                    w_d_neg;

    cordic_atan_rom #(
        .WIDTH (WIDTH)
    ) u_atan_rom (
        .i_idx  (r_i),
        .o_atan (w_atan)
    );

    assign w_xs = r_x >>> r_i;
    assign w_ys = r_y >>> r_i;
    // Steer y toward zero in vectoring, z toward zero in rotation
    assign w_d_neg = (r_mode == MODE_ROT) ? r_z[WIDTH-1] : ~r_y[c_IW-1];

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [c_IW-1:0] w_kx;
    logic signed [c_IW-1:0] w_ky;

    always_comb begin
        w_kx = '0;
        w_ky = '0;
        for (int k = 0; k < c_K_TERMS; k++) begin
            if (c_K_SUB[k]) begin
                w_kx = w_kx - (r_x >>> c_K_SHIFT[k]);
                w_ky = w_ky - (r_y >>> c_K_SHIFT[k]);
            end else begin
                w_kx = w_kx + (r_x >>> c_K_SHIFT[k]);
                w_ky = w_ky + (r_y >>> c_K_SHIFT[k]);
            end
        end
    end
`endif

    // Drop the LSB guard bits with round-half-up, then clamp to WIDTH
    function automatic logic signed [WIDTH-1:0] sat_round(input logic signed [c_IW-1:0] v);
        logic signed [c_IW:0] s;
        logic signed [c_IW:0] q;
        s = {v[c_IW-1], v} + c_HALF;
        q = s >>> GUARD;
        if (q > c_MAX) begin
            q = c_MAX;
        end else if (q < c_MIN) begin
            q = c_MIN;
        end
        return WIDTH'(q);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_VECT;
            r_zero   <= 1'b0;
            r_i      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            crd_busy <= 1'b0;
            crd_done <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
        end else begin
            crd_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (crd_start) begin
                        r_mode   <= crd_mode;
                        r_x      <= {{GUARD{x_in[WIDTH-1]}}, x_in, {GUARD{1'b0}}};
                        r_y      <= {{GUARD{y_in[WIDTH-1]}}, y_in, {GUARD{1'b0}}};
                        r_z      <= z_in;
                        r_i      <= '0;
                        crd_busy <= 1'b1;
                        r_state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_zero <= (r_mode == MODE_VECT) && (r_x == '0) && (r_y == '0);
                    if (r_mode == MODE_VECT) begin
                        if (r_x[c_IW-1]) begin
                            r_x <= -r_x;
                            r_y <= -r_y;
                            // +pi and -pi share one code; the loop settles which side
                            r_z <= c_PI;
                        end else begin
                            r_z <= '0;
                        end
                    end else if ((r_z > c_QTR) || (r_z < c_NQTR)) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_z - c_PI;
                    end
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (w_d_neg) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    r_i <= r_i + 5'd1;
                    if (r_i == c_LAST) begin
                        r_state <= c_AFTER_ITER;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    r_x     <= w_kx;
                    r_y     <= w_ky;
                    r_state <= S_OUT;
                end
`endif
                S_OUT: begin
                    x_out    <= sat_round(r_x);
                    y_out    <= sat_round(r_y);
                    z_out    <= r_zero ? '0 : r_z;
                    crd_done <= 1'b1;
                    crd_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cordic_multi.md
Name: cordic_multi

Overview:
- Parametrised, iterative, multi-mode CORDIC engine; successor to the 24-bit vectoring-only `cordic`.
- Two modes:
  - Vectoring: atan2 and magnitude.
  - Rotation: rotate (x,y) by angle z.
- Full four-quadrant coverage, binary-angle units, optional gain compensation.
- Shared by attitude estimation (tilt angle from accelerometer pairs) and mixer frame rotation.

Parameters:
- WIDTH, 24: signed width of x/y/z inputs and outputs.
- ITERATIONS, 12: micro-rotations performed; legal range 4..WIDTH-2.
- GUARD, 2: extra LSB/MSB guard bits on internal x/y datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- crd_start  in  1  one-cycle request; sampled only when crd_busy=0.
- crd_mode  in  1  0=vectoring, 1=rotation; sampled with crd_start.
- x_in  in  WIDTH  signed x operand.
- y_in  in  WIDTH  signed y operand.
- z_in  in  WIDTH  signed binary angle (rotation mode only), ±2^(WIDTH-1) = ±π.
- crd_busy  out  1  high from the cycle after an accepted start until crd_done.
- crd_done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- x_out  out  WIDTH  vectoring: magnitude; rotation: rotated x.
- y_out  out  WIDTH  vectoring: residual y (≈0); rotation: rotated y.
- z_out  out  WIDTH  vectoring: angle atan2(y,x); rotation: residual angle (≈0).

Behaviour:
- Reset: all outputs 0, FSM=IDLE, internal registers 0. Reset mid-operation aborts without a done pulse.
- Angle format: signed binary angle; 90°=2^(WIDTH-2). Wrap-around is natural two's-complement.
- FSM:
  - IDLE: on crd_start, latch operands/mode, set busy, go to PRE.
  - PRE (1 cycle), quadrant pre-rotation:
    - Vectoring with x<0: negate x and y; z0 = +π if y≥0, else −π.
    - Rotation with |z|>π/2: negate x and y; z -= π (two's wrap).
    - Operands sign-extended by GUARD bits and left-shifted by GUARD.
  - ITER (ITERATIONS cycles, counter i=0..N-1):
    - Direction d = sign(y) in vectoring, sign(z) in rotation.
    - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_lut[i].
    - Arithmetic shifts; no saturation inside the loop.
  - COMP (1 cycle, only if gain compensation is built in; see Optional Feature).
  - OUT (1 cycle):
    - Round x/y by GUARD bits (round-half-up) and saturate to WIDTH.
    - Register outputs, pulse crd_done, drop busy, return to IDLE.
- Latency, start cycle to done: ITERATIONS+2 cycles, or ITERATIONS+3 with compensation. Back-to-back start is allowed in the cycle after done.
- crd_start while busy is ignored (no queueing); operand changes while busy have no effect.
- Vectoring, x=y=0: outputs 0/0/0 (special-cased in PRE, loop still runs for fixed latency).
- Vectoring, x=−2^(WIDTH-1), y=0: angle = −2^(WIDTH-1) (π), magnitude saturated to 2^(WIDTH-1)−1 when uncompensated.
- Vectoring angle for y≥0 with x<0 lands in (π/2, π]; for y<0 with x<0 it lands in [−π, −π/2).

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: COMP state multiplies x and y by K = Π 1/√(1+2^-2i) via a shift-add constant. Outputs are true-scale; latency ITERATIONS+3.
- Undefined: no COMP state. x/y outputs carry gain An (≈1.6468 for N=12); latency ITERATIONS+2.

Decomposition:
- Package cordic_pkg holds:
  - atan table: 32 entries as a binary-angle fraction of π, truncated to WIDTH.
  - gain-K shift-add term list.
  - FSM state enum.
  - mode constants MODE_VECT and MODE_ROT.
- One sub-module: cordic_atan_rom, combinational index → atan_lut[i], scaled to WIDTH.

Test Plan (WIDTH=24, ITERATIONS=12; angle tolerance ±1500 LSB, magnitude ±8):
- Vectoring (10000, 10000) → z_out≈2097152 (45°); x_out≈14142 with COMP, ≈23289 without; done exactly 14 (or 15) cycles after start.
- Vectoring (−10000, 10000), (10000, −10000), (−10000, −10000) → z_out≈6291456, −2097152, −6291456; same magnitudes as above.
- Vectoring (0, 0) → 0/0/0; vectoring (−10000, 0) → z_out≈±8388608 (π).
- Rotation x=10000, y=0, z=4194304 (90°) → x_out≈0, y_out≈10000 (COMP); z=−6291456 (−135°) → x_out≈−7071, y_out≈−7071.
- crd_start pulsed mid-operation with new operands → ignored; result matches the first request; single done pulse.
- rst asserted at iteration 5 → outputs 0, busy 0, no done; new start after reset completes with correct result.
